// File: rtl/dp_pkg.sv
// Shared datapath definitions: writeback selector codes and the default
// link / stack-pointer register numbers used by the control FSM and the queue.
package dp_pkg;

  localparam int unsigned WB_SEL_RT = 0;
  localparam int unsigned WB_SEL_RD = 1;
  localparam int unsigned WB_SEL_RA = 2;
  localparam int unsigned WB_SEL_SP = 3;

  localparam int unsigned RA_REG_DEF = 31;
  localparam int unsigned SP_REG_DEF = 29;

  // Width of an occupancy counter able to hold 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wb_dest_queue_if.sv
// Bus between the control FSM (master) and the writeback destination queue
// (slave): capture request, writeback strobe, status and hazard checks.
interface wb_dest_queue_if
  import dp_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 4,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = cnt_width(DEPTH);

  logic              cap_valid;
  logic              cap_ready;
  logic [SEL_W-1:0]  cap_sel;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_dest;
  logic              wb_we;
  logic              pend_valid;
  logic [CNT_W-1:0]  pend_count;
  logic [ADDR_W-1:0] chk_a;
  logic [ADDR_W-1:0] chk_b;
  logic              hazard_a;
  logic              hazard_b;
  logic              sel_err;

  modport master (
    output cap_valid, cap_sel, rt_addr, rd_addr, wb_en, chk_a, chk_b,
    input  cap_ready, wb_dest, wb_we, pend_valid, pend_count,
           hazard_a, hazard_b, sel_err
  );

  modport slave (
    input  cap_valid, cap_sel, rt_addr, rd_addr, wb_en, chk_a, chk_b,
    output cap_ready, wb_dest, wb_we, pend_valid, pend_count,
           hazard_a, hazard_b, sel_err
  );

endinterface

// File: rtl/wb_dest_decode.sv
// Selector decode: maps a writeback selector code plus the instruction
// rt/rd fields to a register-file destination. Unknown codes give
// destination 0 so the eventual write lands on $zero and is dropped.
module wb_dest_decode
  import dp_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 4,
  parameter int RA_REG = RA_REG_DEF,
  parameter int SP_REG = SP_REG_DEF
) (
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [ADDR_W-1:0] i_rt,
  input  logic [ADDR_W-1:0] i_rd,
  output logic [ADDR_W-1:0] o_dest,
  output logic              o_invalid
);

  // Pure combinational selector mux with an invalid flag.
  always_comb begin
    o_dest    = '0;
    o_invalid = 1'b0;
    case (i_sel)
      SEL_W'(WB_SEL_RT): o_dest = i_rt;
      SEL_W'(WB_SEL_RD): o_dest = i_rd;
      SEL_W'(WB_SEL_RA): o_dest = ADDR_W'(RA_REG);
      SEL_W'(WB_SEL_SP): o_dest = ADDR_W'(SP_REG);
      default:           o_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_dest_queue.sv
// Writeback destination queue: captures decoded destinations at decode,
// presents the oldest one to the register-file write port, retires it on
// the writeback strobe, and flags RAW hazards against every pending entry.
module wb_dest_queue
  import dp_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 4,
  parameter int DEPTH  = 2,
  parameter int RA_REG = RA_REG_DEF,
  parameter int SP_REG = SP_REG_DEF
) (
  input logic            clk,
  input logic            reset_n,
  wb_dest_queue_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_width(DEPTH);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_sel_err;

  logic [ADDR_W-1:0] w_dec_dest;
  logic              w_dec_invalid;
  logic              w_cap_ready;
  logic              w_pend;
  logic              w_cap;
  logic              w_ret;
  logic [ADDR_W-1:0] w_head_dest;
  logic [DEPTH-1:0]  w_entry_valid;
  logic              w_haz_a;
  logic              w_haz_b;

  wb_dest_decode #(
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W),
    .RA_REG (RA_REG),
    .SP_REG (SP_REG)
  ) u_decode (
    .i_sel     (bus.cap_sel),
    .i_rt      (bus.rt_addr),
    .i_rd      (bus.rd_addr),
    .o_dest    (w_dec_dest),
    .o_invalid (w_dec_invalid)
  );

  // Readiness comes from the registered count only, so a full queue never
  // reuses the slot being retired in the same cycle.
  assign w_cap_ready = (r_count < CNT_W'(DEPTH));
  assign w_pend      = (r_count != '0);
  assign w_cap       = bus.cap_valid & w_cap_ready;
  assign w_ret       = bus.wb_en & w_pend;
  assign w_head_dest = w_pend ? r_mem[r_head] : '0;

  // Entry i is live when its distance from head is below the count.
  always_comb begin
    w_entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_entry_valid[i] = (((i + DEPTH - int'(r_head)) % DEPTH) < int'(r_count));
    end
  end

  // RAW check against all live entries; $zero never hazards.
  always_comb begin
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entry_valid[i] && (r_mem[i] != '0) && (r_mem[i] == bus.chk_a)) w_haz_a = 1'b1;
      if (w_entry_valid[i] && (r_mem[i] != '0) && (r_mem[i] == bus.chk_b)) w_haz_b = 1'b1;
    end
  end

  // Pointer, count, storage and sticky error update.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_sel_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_cap) begin
        r_mem[r_tail] <= w_dec_dest;
        r_tail        <= (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + 1'b1;
        if (w_dec_invalid) r_sel_err <= 1'b1;
      end
      if (w_ret) begin
        r_head <= (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + 1'b1;
      end
      case ({w_cap, w_ret})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // An in-flight strobe during reset must not reach the register file.
  assign bus.wb_we      = w_ret & (w_head_dest != '0) & reset_n;
  assign bus.wb_dest    = w_head_dest;
  assign bus.cap_ready  = w_cap_ready;
  assign bus.pend_valid = w_pend;
  assign bus.pend_count = r_count;
  assign bus.hazard_a   = w_haz_a;
  assign bus.hazard_b   = w_haz_b;
  assign bus.sel_err    = r_sel_err;

endmodule
